// File: rtl/hwpe_ctrl_uloop_engine.sv
// Nested-loop microcode engine: walks NB_LOOPS counters, runs an offset-update
// microcode sequence on every loop advance and emits one beat per inner iteration.
module hwpe_ctrl_uloop_engine #(
  parameter int unsigned NB_LOOPS  = 6,
  parameter int unsigned NB_REG    = 4,
  parameter int unsigned NB_RO_REG = 28,
  parameter int unsigned LENGTH    = 16,
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 12,
  parameter int unsigned LOOP_W    = (NB_LOOPS > 1) ? $clog2(NB_LOOPS) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic                           start_i,
  input  logic [LOOP_W-1:0]              accum_loop_i,
  input  logic [NB_LOOPS*5-1:0]          loops_addr_i,
  input  logic [NB_LOOPS*3-1:0]          loops_nbops_i,
  input  logic [LENGTH*11-1:0]           code_i,
  input  logic [NB_LOOPS*CNT_WIDTH-1:0]  range_i,
  input  logic [NB_RO_REG*REG_WIDTH-1:0] ro_reg_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [NB_REG*REG_WIDTH-1:0]    offs_o,
  output logic [NB_LOOPS*CNT_WIDTH-1:0]  idx_o,
  output logic                           accum_o,
  output logic                           busy_o,
  output logic                           done_o
);

  localparam int unsigned SLOT_W = 6;
  localparam int unsigned NBOP_W = 3;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned OP_W   = 11;
  localparam int unsigned CW1    = CNT_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, EMIT, EXEC, DONE} state_t;

  state_t               state_q;
  logic [REG_WIDTH-1:0] offs_q [NB_REG];
  logic [CNT_WIDTH-1:0] idx_q  [NB_LOOPS];
  logic [LOOP_W-1:0]    cur_loop_q;
  logic [NBOP_W-1:0]    op_cnt_q;
  logic                 valid_q;
  logic                 accum_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 adv_found;
  logic [LOOP_W-1:0]    adv_loop;
  logic [NBOP_W-1:0]    adv_nbops;
  logic [CNT_WIDTH-1:0] idx_adv [NB_LOOPS];
  logic                 accum_adv;
  logic [NBOP_W-1:0]    cur_nbops;
  logic [ADDR_W-1:0]    cur_addr;
  logic [SLOT_W-1:0]    slot;
  logic [OP_W-1:0]      instr;
  logic                 op_valid;
  logic                 op_last;
  logic [REG_WIDTH-1:0] operand;

  // A loop can advance while idx+1 < max(range,1)
  function automatic logic can_advance(input logic [CNT_WIDTH-1:0] idx,
                                       input logic [CNT_WIDTH-1:0] rng);
    logic [CW1-1:0] eff;
    eff = (rng == '0) ? CW1'(1) : {1'b0, rng};
    return ({1'b0, idx} + CW1'(1)) < eff;
  endfunction

  // Lowest loop that still has iterations left
  always_comb begin
    adv_found = 1'b0;
    adv_loop  = '0;
    adv_nbops = '0;
    for (int l = 0; l < NB_LOOPS; l++) begin
      if (!adv_found && can_advance(idx_q[l], range_i[l*CNT_WIDTH +: CNT_WIDTH])) begin
        adv_found = 1'b1;
        adv_loop  = LOOP_W'(l);
        adv_nbops = loops_nbops_i[l*NBOP_W +: NBOP_W];
      end
    end
  end

  // Indices after the advance, and the accumulation flag they imply
  always_comb begin
    accum_adv = 1'b0;
    for (int l = 0; l < NB_LOOPS; l++) begin
      idx_adv[l] = idx_q[l];
      if (adv_found && (LOOP_W'(l) == adv_loop)) begin
        idx_adv[l] = idx_q[l] + CNT_WIDTH'(1);
      end else if (adv_found && (LOOP_W'(l) < adv_loop)) begin
        idx_adv[l] = '0;
      end
      if ((LOOP_W'(l) < accum_loop_i) && (idx_adv[l] != '0)) begin
        accum_adv = 1'b1;
      end
    end
  end

  // Microcode fetch and operand select for the op currently executing
  always_comb begin
    cur_nbops = '0;
    cur_addr  = '0;
    for (int l = 0; l < NB_LOOPS; l++) begin
      if (LOOP_W'(l) == cur_loop_q) begin
        cur_nbops = loops_nbops_i[l*NBOP_W +: NBOP_W];
        cur_addr  = loops_addr_i[l*ADDR_W +: ADDR_W];
      end
    end
    slot     = SLOT_W'(cur_addr) + SLOT_W'(op_cnt_q);
    instr    = '0;
    op_valid = 1'b0;
    for (int s = 0; s < LENGTH; s++) begin
      if (SLOT_W'(s) == slot) begin
        instr    = code_i[s*OP_W +: OP_W];
        op_valid = 1'b1;
      end
    end
    operand = '0;
    if (instr[10]) begin
      for (int r = 0; r < NB_RO_REG; r++) begin
        if (5'(r) == instr[4:0]) operand = ro_reg_i[r*REG_WIDTH +: REG_WIDTH];
      end
    end else begin
      for (int r = 0; r < NB_REG; r++) begin
        if (5'(r) == instr[4:0]) operand = offs_q[r];
      end
    end
    op_last = ({1'b0, op_cnt_q} + 4'd1) == {1'b0, cur_nbops};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cur_loop_q <= '0;
      op_cnt_q   <= '0;
      valid_q    <= 1'b0;
      accum_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int r = 0; r < NB_REG; r++) offs_q[r] <= '0;
      for (int l = 0; l < NB_LOOPS; l++) idx_q[l] <= '0;
    end else if (clear_i) begin
      state_q    <= IDLE;
      cur_loop_q <= '0;
      op_cnt_q   <= '0;
      valid_q    <= 1'b0;
      accum_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int r = 0; r < NB_REG; r++) offs_q[r] <= '0;
      for (int l = 0; l < NB_LOOPS; l++) idx_q[l] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q  <= EMIT;
            valid_q  <= 1'b1;
            busy_q   <= 1'b1;
            accum_q  <= 1'b0;
            op_cnt_q <= '0;
            for (int r = 0; r < NB_REG; r++) offs_q[r] <= '0;
            for (int l = 0; l < NB_LOOPS; l++) idx_q[l] <= '0;
          end
        end
        EMIT: begin
          if (ready_i) begin
            if (adv_found) begin
              for (int l = 0; l < NB_LOOPS; l++) idx_q[l] <= idx_adv[l];
              accum_q    <= accum_adv;
              cur_loop_q <= adv_loop;
              op_cnt_q   <= '0;
              if (adv_nbops != '0) begin
                state_q <= EXEC;
                valid_q <= 1'b0;
              end
            end else begin
              state_q <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        EXEC: begin
          for (int r = 0; r < NB_REG; r++) begin
            if (op_valid && (5'(r) == instr[9:5])) offs_q[r] <= offs_q[r] + operand;
          end
          if (op_last) begin
            state_q  <= EMIT;
            valid_q  <= 1'b1;
            op_cnt_q <= '0;
          end else begin
            op_cnt_q <= op_cnt_q + NBOP_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < NB_REG; r++) begin : g_offs
    assign offs_o[r*REG_WIDTH +: REG_WIDTH] = offs_q[r];
  end
  for (genvar l = 0; l < NB_LOOPS; l++) begin : g_idx
    assign idx_o[l*CNT_WIDTH +: CNT_WIDTH] = idx_q[l];
  end

  assign valid_o = valid_q;
  assign accum_o = accum_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule
